// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline run/step/halt sequencer.
package pipe_ctrl_pkg;
    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_HALT  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_HOST  = 2'b01;
    localparam logic [1:0] CAUSE_INSTR = 2'b10;
    localparam logic [1:0] CAUSE_BP    = 2'b11;

    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4,
        CLEAR  = 3'd5
    } runState_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset || clr) count <= '0;
        else if (inc && count != '1) count <= count + W'(1);
    end
endmodule

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: run/step/halt sequencer producing the pipeline enable and clear.
module pipeline_run_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          PC_W         = 10,
    parameter logic [31:0] HALT_WORD    = HALT_WORD_DEF,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          CLR_CYCLES   = 2,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    input  logic [31:0]      instruction,
    input  logic [PC_W-1:0]  pc,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_pc,
    output logic             pipe_en,
    output logic             pipe_reset,
    output logic             halted,
    output logic [2:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int CW = $clog2(CLR_CYCLES + 1);

    runState_e     cur, nxt;
    logic [1:0]    cause, causeNext;
    logic [DW-1:0] drainCnt, drainNext;
    logic [CW-1:0] clrCnt, clrNext;
    logic          bpMask, maskNext, cntClr;
    logic          accepted, haltFetch, bpHit;

    assign pipe_en    = cur inside {RUN, STEP, DRAIN};
    assign pipe_reset = cur == CLEAR;
    assign cmd_ready  = cur inside {IDLE, RUN, HALTED};
    assign halted     = cur == HALTED;
    assign state      = cur;
    assign halt_cause = cause;
    assign accepted   = cmd_valid && cmd_ready;
    assign haltFetch  = instruction == HALT_WORD;
    assign bpHit      = bp_en && pc == bp_pc && !bpMask;

    always_comb begin
        nxt       = cur;
        causeNext = cause;
        drainNext = drainCnt;
        clrNext   = clrCnt;
        maskNext  = pipe_en ? 1'b0 : bpMask;
        case (cur)
            IDLE: if (accepted) begin
                nxt = cmd == CMD_RUN  ? RUN :
                      cmd == CMD_STEP ? STEP :
                      cmd == CMD_HALT ? HALTED : CLEAR;
                if (cmd == CMD_HALT) causeNext = CAUSE_HOST;
            end
            // pipeline events outrank any command presented in the same cycle
            RUN: if (haltFetch) begin
                nxt = DRAIN;
                causeNext = CAUSE_INSTR;
            end else if (bpHit) begin
                nxt = HALTED;
                causeNext = CAUSE_BP;
            end else if (accepted && cmd == CMD_HALT) begin
                nxt = HALTED;
                causeNext = CAUSE_HOST;
            end else if (accepted && cmd == CMD_CLEAR) begin
                nxt = CLEAR;
            end
            STEP: begin
                nxt = haltFetch ? DRAIN : IDLE;
                if (haltFetch) causeNext = CAUSE_INSTR;
            end
            DRAIN: begin
                nxt = drainCnt <= DW'(1) ? HALTED : DRAIN;
                drainNext = drainCnt - DW'(1);
            end
            HALTED: if (accepted && cmd == CMD_CLEAR) begin
                nxt = CLEAR;
            end else if (accepted && (cmd == CMD_RUN || cmd == CMD_STEP) &&
                         (cause == CAUSE_BP || cause == CAUSE_HOST)) begin
                nxt = cmd == CMD_RUN ? RUN : STEP;
                // mask the compare for one cycle so we can step off the breakpoint PC
                if (cause == CAUSE_BP) begin
                    causeNext = CAUSE_NONE;
                    maskNext = 1'b1;
                end
            end
            CLEAR: begin
                nxt = clrCnt <= CW'(1) ? IDLE : CLEAR;
                clrNext = clrCnt - CW'(1);
            end
            default: nxt = IDLE;
        endcase
        cntClr = nxt == CLEAR && cur != CLEAR;
        if (nxt == DRAIN && cur != DRAIN) drainNext = DW'(DRAIN_CYCLES);
        if (cntClr) begin
            clrNext = CW'(CLR_CYCLES);
            causeNext = CAUSE_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= IDLE;
            cause    <= CAUSE_NONE;
            drainCnt <= '0;
            clrCnt   <= '0;
            bpMask   <= 1'b0;
        end else begin
            cur      <= nxt;
            cause    <= causeNext;
            drainCnt <= drainNext;
            clrCnt   <= clrNext;
            bpMask   <= maskNext;
        end
    end

    sat_counter #(.W(CNT_W)) uCycles (
        .clk(clk),
        .reset(reset),
        .inc(pipe_en),
        .clr(cntClr),
        .count(cycle_count)
    );
endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl: table-driven and directed checks of the run/step/halt sequencer.
module tb_pipeline_run_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [31:0] HW = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic [31:0] instruction = '0;
    logic [9:0]  pc = '0;
    logic        bp_en = 1'b0;
    logic [9:0]  bp_pc = '0;
    logic        cmd_ready, pipe_en, pipe_reset, halted;
    logic [2:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;
    logic        cmd_ready2, pipe_en2, pipe_reset2, halted2;
    logic [2:0]  state2;
    logic [1:0]  halt_cause2;
    logic [2:0]  cycle_count2;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipeline_run_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .instruction(instruction), .pc(pc), .bp_en(bp_en), .bp_pc(bp_pc),
        .pipe_en(pipe_en), .pipe_reset(pipe_reset), .halted(halted), .state(state),
        .halt_cause(halt_cause), .cycle_count(cycle_count)
    );

    // narrow counter copy so saturation is reachable in a short run
    pipeline_run_ctrl #(.CNT_W(3)) dutSat (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready2),
        .instruction(instruction), .pc(pc), .bp_en(bp_en), .bp_pc(bp_pc),
        .pipe_en(pipe_en2), .pipe_reset(pipe_reset2), .halted(halted2), .state(state2),
        .halt_cause(halt_cause2), .cycle_count(cycle_count2)
    );

    typedef struct {
        logic v; logic [1:0] c; logic [31:0] ins;
        logic [2:0] st; logic en; logic rs; logic rdy; logic [1:0] cause; logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic v, input logic [1:0] c, input logic [31:0] ins,
                                 input logic [2:0] st, input logic en, input logic rs,
                                 input logic rdy, input logic [1:0] cause, input logic [31:0] cnt);
        vec_t r;
        r.v = v; r.c = c; r.ins = ins; r.st = st; r.en = en; r.rs = rs;
        r.rdy = rdy; r.cause = cause; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic checkAll(input string name, input logic [2:0] st, input logic en,
                            input logic rs, input logic rdy, input logic [1:0] cause,
                            input logic [31:0] cnt);
        chk({name, " state"}, 32'(state), 32'(st));
        chk({name, " pipe_en"}, 32'(pipe_en), 32'(en));
        chk({name, " pipe_reset"}, 32'(pipe_reset), 32'(rs));
        chk({name, " cmd_ready"}, 32'(cmd_ready), 32'(rdy));
        chk({name, " halted"}, 32'(halted), 32'(st == 3'd4));
        chk({name, " halt_cause"}, 32'(halt_cause), 32'(cause));
        chk({name, " cycle_count"}, cycle_count, cnt);
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] ins,
                         input logic [9:0] pcv);
        cmd_valid = v; cmd = c; instruction = ins; pc = pcv;
        @(negedge clk);
    endtask

    initial begin
        tbl.push_back(row(1, CMD_STEP, 0, 2, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(row(1, CMD_STEP, 0, 2, 1, 0, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 0, 2));
        tbl.push_back(row(1, CMD_STEP, 0, 2, 1, 0, 0, 0, 2));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 0, 3));
        tbl.push_back(row(1, CMD_RUN, 0, 1, 1, 0, 1, 0, 3));
        for (int j = 0; j < 10; j++)
            tbl.push_back(row(j == 4, CMD_RUN, 32'h2000_0000 + j, 1, 1, 0, 1, 0, 4 + j));
        tbl.push_back(row(0, 0, HW, 3, 1, 0, 0, 2, 14));
        tbl.push_back(row(1, CMD_RUN, HW, 3, 1, 0, 0, 2, 15));
        tbl.push_back(row(0, 0, 0, 3, 1, 0, 0, 2, 16));
        tbl.push_back(row(0, 0, 0, 3, 1, 0, 0, 2, 17));
        tbl.push_back(row(0, 0, 0, 4, 0, 0, 1, 2, 18));
        tbl.push_back(row(1, CMD_RUN, 0, 4, 0, 0, 1, 2, 18));
        tbl.push_back(row(1, CMD_STEP, 0, 4, 0, 0, 1, 2, 18));
        tbl.push_back(row(1, CMD_HALT, 0, 4, 0, 0, 1, 2, 18));
        tbl.push_back(row(1, CMD_CLEAR, 0, 5, 0, 1, 0, 0, 0));
        tbl.push_back(row(1, CMD_RUN, 0, 5, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 0, 0));

        @(negedge clk);
        @(negedge clk);
        checkAll("reset", 0, 0, 0, 1, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].c, tbl[i].ins, 0);
            checkAll($sformatf("vec%0d", i), tbl[i].st, tbl[i].en, tbl[i].rs, tbl[i].rdy,
                     tbl[i].cause, tbl[i].cnt);
        end

        bp_en = 1'b1;
        bp_pc = 10'h008;
        drive(1, CMD_RUN, 0, 6);    checkAll("bp run", 1, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 7);          checkAll("bp pc7", 1, 1, 0, 1, 0, 1);
        drive(0, 0, 0, 8);          checkAll("bp hit", 4, 0, 0, 1, 3, 2);
        drive(0, 0, 0, 8);          checkAll("bp hold", 4, 0, 0, 1, 3, 2);
        drive(1, CMD_RUN, 0, 8);    checkAll("bp resume", 1, 1, 0, 1, 0, 2);
        drive(0, 0, 0, 8);          checkAll("bp masked", 1, 1, 0, 1, 0, 3);
        drive(0, 0, 0, 9);          checkAll("bp past", 1, 1, 0, 1, 0, 4);
        drive(0, 0, 0, 8);          checkAll("bp rearm", 4, 0, 0, 1, 3, 5);
        drive(1, CMD_HALT, 0, 8);   checkAll("bp halt nop", 4, 0, 0, 1, 3, 5);
        bp_en = 1'b0;
        drive(1, CMD_STEP, 0, 8);   checkAll("bp step", 2, 1, 0, 0, 0, 5);
        drive(0, 0, 0, 9);          checkAll("bp step end", 0, 0, 0, 1, 0, 6);

        drive(1, CMD_RUN, 0, 9);    checkAll("prio run", 1, 1, 0, 1, 0, 6);
        drive(1, CMD_HALT, HW, 10); checkAll("prio drain", 3, 1, 0, 0, 2, 7);
        drive(0, 0, 0, 0);          checkAll("prio d2", 3, 1, 0, 0, 2, 8);
        drive(0, 0, 0, 0);          checkAll("prio d3", 3, 1, 0, 0, 2, 9);
        drive(0, 0, 0, 0);          checkAll("prio d4", 3, 1, 0, 0, 2, 10);
        drive(0, 0, 0, 0);          checkAll("prio halted", 4, 0, 0, 1, 2, 11);
        drive(1, CMD_HALT, 0, 0);   checkAll("prio halt nop", 4, 0, 0, 1, 2, 11);
        drive(1, CMD_CLEAR, 0, 0);  checkAll("clr1", 5, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0);          checkAll("clr2", 5, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0);          checkAll("clr done", 0, 0, 0, 1, 0, 0);

        drive(1, CMD_RUN, 0, 0);    checkAll("host run", 1, 1, 0, 1, 0, 0);
        drive(1, CMD_HALT, 0, 0);   checkAll("host halt", 4, 0, 0, 1, 1, 1);
        drive(1, CMD_RUN, 0, 0);    checkAll("host resume", 1, 1, 0, 1, 1, 1);
        drive(0, 0, 0, 0);          checkAll("host running", 1, 1, 0, 1, 1, 2);

        drive(0, 0, HW, 0);         checkAll("rst drain1", 3, 1, 0, 0, 2, 3);
        drive(0, 0, 0, 0);          checkAll("rst drain2", 3, 1, 0, 0, 2, 4);
        drive(0, 0, 0, 0);          checkAll("rst drain3", 3, 1, 0, 0, 2, 5);
        reset = 1'b1;
        drive(1, CMD_RUN, 0, 0);    checkAll("rst mid drain", 0, 0, 0, 1, 0, 0);
        reset = 1'b0;

        drive(1, CMD_RUN, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            drive(0, 0, 0, 0);
            if (k == 6) chk("sat below", 32'(cycle_count2), 6);
        end
        chk("sat wide count", cycle_count, 10);
        chk("sat narrow count", 32'(cycle_count2), 7);
        chk("sat narrow state", 32'(state2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
